// File: rtl/z88_ps2kbd.sv
// z88_ps2kbd: receive-only PS/2 (scan code set 2) keyboard front end for the
// Z88 gate array. Builds the 64-bit pressed-key matrix consumed by blink.
// Optional build macro: PS2_TIMEOUT_EN compiles in the mid-frame stall abort.
module z88_ps2kbd #(
    parameter int unsigned FILT    = 8,
    parameter int unsigned TIMEOUT = 2000
) (
    input  logic        mck,
    input  logic        rin,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [63:0] kbmat,
    output logic        key_evt,
    output logic        frm_err
);

    localparam int unsigned FCW = $clog2(FILT + 1);
`ifdef PS2_TIMEOUT_EN
    localparam int unsigned TCW = $clog2(TIMEOUT);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_t;

    // index 0 = ps2_clk, index 1 = ps2_dat
    logic [1:0]     raw_c;
    logic [1:0]     sync_a;
    logic [1:0]     sync_b;
    logic [1:0]     filt;
    logic [FCW-1:0] fcnt [2];
    logic           clk_prev;
    logic           fall_c;
    logic           dat_c;

    rx_state_t      state;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;
    logic           par_bit;
    logic           byte_stb;
    logic [7:0]     byte_q;
`ifdef PS2_TIMEOUT_EN
    logic [TCW-1:0] tcnt;
`endif

    logic           ext;
    logic           brk;
    logic [6:0]     map_c;

    assign raw_c  = {ps2_dat, ps2_clk};
    assign fall_c = clk_prev & ~filt[0];
    assign dat_c  = filt[1];

    // Two-flop synchronisers followed by a FILT-sample persistence filter.
    always_ff @(posedge mck or posedge rin) begin
        if (rin) begin
            sync_a   <= 2'b11;
            sync_b   <= 2'b11;
            filt     <= 2'b11;
            clk_prev <= 1'b1;
            for (int i = 0; i < 2; i++) fcnt[i] <= '0;
        end else begin
            sync_a   <= raw_c;
            sync_b   <= sync_a;
            clk_prev <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FCW'(FILT - 1)) begin
                    filt[i] <= sync_b[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FCW'(1);
                end
            end
        end
    end

    // Frame receiver: start, 8 data bits LSB first, odd parity, stop.
    always_ff @(posedge mck or posedge rin) begin
        if (rin) begin
            state    <= S_IDLE;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            par_bit  <= 1'b0;
            byte_stb <= 1'b0;
            byte_q   <= 8'h00;
            frm_err  <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            tcnt     <= '0;
`endif
        end else begin
            byte_stb <= 1'b0;
            frm_err  <= 1'b0;
            if (fall_c) begin
                case (state)
                    S_IDLE: begin
                        if (!dat_c) begin
                            state   <= S_DATA;
                            bit_cnt <= 3'd0;
                        end else begin
                            frm_err <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        shreg   <= {dat_c, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_PARITY;
                    end
                    S_PARITY: begin
                        par_bit <= dat_c;
                        state   <= S_STOP;
                    end
                    S_STOP: begin
                        if (dat_c && (^{shreg, par_bit})) begin
                            byte_stb <= 1'b1;
                            byte_q   <= shreg;
                        end else begin
                            frm_err <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
`ifdef PS2_TIMEOUT_EN
            // Abort a stalled frame; prefix flags in the decoder are untouched.
            if (fall_c || state == S_IDLE) begin
                tcnt <= '0;
            end else if (tcnt == TCW'(TIMEOUT - 1)) begin
                tcnt    <= '0;
                state   <= S_IDLE;
                frm_err <= 1'b1;
            end else begin
                tcnt <= tcnt + TCW'(1);
            end
`endif
        end
    end

`ifndef PS2_TIMEOUT_EN
    // TIMEOUT has no effect in this build; kept so both builds share one interface.
    if (TIMEOUT == 0) begin : g_timeout_unused
    end
`endif

    // Scan code {ext, code} -> {valid, matrix index 8*col+row}.
    function automatic logic [6:0] keymap(input logic [8:0] key);
        case (key)
            9'h03E: keymap = {1'b1, 6'd0};   // 8
            9'h03D: keymap = {1'b1, 6'd1};   // 7
            9'h031: keymap = {1'b1, 6'd2};   // N
            9'h175: keymap = {1'b1, 6'd3};   // UP
            9'h16B: keymap = {1'b1, 6'd4};   // LEFT
            9'h174: keymap = {1'b1, 6'd5};   // RIGHT
            9'h05A: keymap = {1'b1, 6'd6};   // ENTER
            9'h066: keymap = {1'b1, 6'd7};   // DEL
            9'h055: keymap = {1'b1, 6'd8};   // =
            9'h04E: keymap = {1'b1, 6'd9};   // -
            9'h03A: keymap = {1'b1, 6'd10};  // M
            9'h172: keymap = {1'b1, 6'd11};  // DOWN
            9'h03C: keymap = {1'b1, 6'd12};  // U
            9'h03B: keymap = {1'b1, 6'd13};  // J
            9'h033: keymap = {1'b1, 6'd14};  // H
            9'h059: keymap = {1'b1, 6'd15};  // right SHIFT
            9'h045: keymap = {1'b1, 6'd16};  // 0
            9'h046: keymap = {1'b1, 6'd17};  // 9
            9'h042: keymap = {1'b1, 6'd18};  // K
            9'h043: keymap = {1'b1, 6'd19};  // I
            9'h036: keymap = {1'b1, 6'd20};  // 6
            9'h035: keymap = {1'b1, 6'd21};  // Y
            9'h032: keymap = {1'b1, 6'd22};  // B
            9'h05D: keymap = {1'b1, 6'd23};  // backslash
            9'h04D: keymap = {1'b1, 6'd24};  // P
            9'h044: keymap = {1'b1, 6'd25};  // O
            9'h04B: keymap = {1'b1, 6'd26};  // L
            9'h041: keymap = {1'b1, 6'd27};  // ,
            9'h02E: keymap = {1'b1, 6'd28};  // 5
            9'h02C: keymap = {1'b1, 6'd29};  // T
            9'h034: keymap = {1'b1, 6'd30};  // G
            9'h02A: keymap = {1'b1, 6'd31};  // V
            9'h052: keymap = {1'b1, 6'd32};  // '
            9'h04C: keymap = {1'b1, 6'd33};  // ;
            9'h049: keymap = {1'b1, 6'd34};  // .
            9'h04A: keymap = {1'b1, 6'd35};  // /
            9'h025: keymap = {1'b1, 6'd36};  // 4
            9'h02D: keymap = {1'b1, 6'd37};  // R
            9'h02B: keymap = {1'b1, 6'd38};  // F
            9'h021: keymap = {1'b1, 6'd39};  // C
            9'h054: keymap = {1'b1, 6'd40};  // [
            9'h05B: keymap = {1'b1, 6'd41};  // ]
            9'h00E: keymap = {1'b1, 6'd42};  // pound (backtick key)
            9'h026: keymap = {1'b1, 6'd43};  // 3
            9'h024: keymap = {1'b1, 6'd44};  // E
            9'h01C: keymap = {1'b1, 6'd45};  // A
            9'h023: keymap = {1'b1, 6'd46};  // D
            9'h022: keymap = {1'b1, 6'd47};  // X
            9'h076: keymap = {1'b1, 6'd48};  // ESC
            9'h005: keymap = {1'b1, 6'd49};  // INDEX (F1)
            9'h006: keymap = {1'b1, 6'd50};  // MENU (F2)
            9'h004: keymap = {1'b1, 6'd51};  // HELP (F3)
            9'h01E: keymap = {1'b1, 6'd52};  // 2
            9'h029: keymap = {1'b1, 6'd53};  // SPACE
            9'h01B: keymap = {1'b1, 6'd54};  // S
            9'h01A: keymap = {1'b1, 6'd55};  // Z
            9'h016: keymap = {1'b1, 6'd56};  // 1
            9'h015: keymap = {1'b1, 6'd57};  // Q
            9'h01D: keymap = {1'b1, 6'd58};  // W
            9'h00D: keymap = {1'b1, 6'd59};  // TAB
            9'h014: keymap = {1'b1, 6'd60};  // DIAMOND (left CTRL)
            9'h011: keymap = {1'b1, 6'd61};  // SQUARE (left ALT)
            9'h012: keymap = {1'b1, 6'd62};  // left SHIFT
            9'h058: keymap = {1'b1, 6'd63};  // CAPS LOCK
            default: keymap = 7'h00;
        endcase
    endfunction

    assign map_c = keymap({ext, byte_q});

    // Decoder: prefix tracking, self-test clear, and matrix bit update.
    always_ff @(posedge mck or posedge rin) begin
        if (rin) begin
            kbmat   <= 64'h0;
            key_evt <= 1'b0;
            ext     <= 1'b0;
            brk     <= 1'b0;
        end else begin
            key_evt <= 1'b0;
            if (byte_stb) begin
                case (byte_q)
                    8'hE0: ext <= 1'b1;
                    8'hF0: brk <= 1'b1;
                    8'hAA, 8'hFC: begin
                        kbmat <= 64'h0;
                        ext   <= 1'b0;
                        brk   <= 1'b0;
                    end
                    default: begin
                        if (map_c[6]) begin
                            kbmat[map_c[5:0]] <= ~brk;
                            key_evt           <= 1'b1;
                        end
                        ext <= 1'b0;
                        brk <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_z88_ps2kbd.sv
// tb_z88_ps2kbd: drives PS/2 frames into z88_ps2kbd and compares the key
// matrix and pulse counts with a scan-code level model of the keyboard.
module tb_z88_ps2kbd;

    localparam int unsigned FILT    = 8;
    localparam int unsigned TIMEOUT = 2000;
    localparam int          HALF    = 16;
    localparam int          GAP     = 30;

    logic        mck = 1'b0;
    logic        rin = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [63:0] kbmat;
    logic        key_evt;
    logic        frm_err;

    int n_tests = 0;
    int n_fail  = 0;
    int evt_cnt = 0;
    int err_cnt = 0;
    int exp_evt = 0;
    int exp_err = 0;

    logic [63:0] mdl_mat = 64'h0;
    bit          m_ext   = 1'b0;
    bit          m_brk   = 1'b0;

    // Key table: entry i is the {ext, code} of the key at matrix index i.
    logic [8:0] km_key [64] = '{
        9'h03E, 9'h03D, 9'h031, 9'h175, 9'h16B, 9'h174, 9'h05A, 9'h066,
        9'h055, 9'h04E, 9'h03A, 9'h172, 9'h03C, 9'h03B, 9'h033, 9'h059,
        9'h045, 9'h046, 9'h042, 9'h043, 9'h036, 9'h035, 9'h032, 9'h05D,
        9'h04D, 9'h044, 9'h04B, 9'h041, 9'h02E, 9'h02C, 9'h034, 9'h02A,
        9'h052, 9'h04C, 9'h049, 9'h04A, 9'h025, 9'h02D, 9'h02B, 9'h021,
        9'h054, 9'h05B, 9'h00E, 9'h026, 9'h024, 9'h01C, 9'h023, 9'h022,
        9'h076, 9'h005, 9'h006, 9'h004, 9'h01E, 9'h029, 9'h01B, 9'h01A,
        9'h016, 9'h015, 9'h01D, 9'h00D, 9'h014, 9'h011, 9'h012, 9'h058
    };

    z88_ps2kbd #(.FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
        .mck     (mck),
        .rin     (rin),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .kbmat   (kbmat),
        .key_evt (key_evt),
        .frm_err (frm_err)
    );

    always #5 mck = ~mck;

    // Pulse counters for the two one-cycle outputs.
    always @(posedge mck) begin
        if (key_evt === 1'b1) evt_cnt++;
        if (frm_err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Keyboard behaviour for one accepted byte, straight from the scan-code rules.
    task automatic mdl_byte(input logic [7:0] b);
        int idx;
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hAA || b == 8'hFC) begin
            mdl_mat = 64'h0;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            idx = -1;
            for (int i = 0; i < 64; i++)
                if (km_key[i] == {m_ext, b}) idx = i;
            if (idx >= 0) begin
                mdl_mat[idx] = !m_brk;
                exp_evt++;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic ps2_bit(input logic b, input bit glitch);
        @(negedge mck);
        ps2_dat = b;
        repeat (HALF / 2) @(negedge mck);
        if (glitch) begin
            ps2_clk = 1'b0;
            @(negedge mck);
            ps2_clk = 1'b1;
        end
        repeat (HALF / 2) @(negedge mck);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge mck);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
        logic par;
        par = ~(^b) ^ bad_par;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch && i == 3);
        ps2_bit(par, 1'b0);
        ps2_bit(1'b1, 1'b0);
        @(negedge mck);
        ps2_dat = 1'b1;
        repeat (GAP) @(negedge mck);
        if (bad_par) exp_err++;
        else mdl_byte(b);
    endtask

    task automatic send_key(input int k, input bit rel);
        if (km_key[k][8]) send_frame(8'hE0, 1'b0, 1'b0);
        if (rel) send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(km_key[k][7:0], 1'b0, 1'b0);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_kbmat"}, kbmat, mdl_mat);
        check({tag, "_evts"}, 64'(evt_cnt), 64'(exp_evt));
        check({tag, "_errs"}, 64'(err_cnt), 64'(exp_err));
    endtask

    initial begin
        int r;
        int k;
        logic [7:0] b;

        // Reset state.
        repeat (4) @(negedge mck);
        check("rst_kbmat", kbmat, 64'h0);
        check("rst_evt", 64'(key_evt), 64'h0);
        check("rst_err", 64'(frm_err), 64'h0);
        rin = 1'b0;
        repeat (20) @(negedge mck);

        // Make then break of A.
        send_frame(8'h1C, 1'b0, 1'b0);
        check("make_a_bit", kbmat, 64'h1 << 45);
        check_all("make_a");
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("brk_a_bit", kbmat, 64'h0);
        check_all("brk_a");

        // Extended UP with left SHIFT held.
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        send_frame(8'h12, 1'b0, 1'b0);
        check("up_shift", kbmat, (64'h1 << 3) | (64'h1 << 62));
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        check("up_rel", kbmat, 64'h1 << 62);
        check_all("ext");

        // Parity error drops the byte; a clean retry is accepted.
        send_frame(8'h5A, 1'b1, 1'b0);
        check_all("bad_par");
        send_frame(8'h5A, 1'b0, 1'b0);
        check("enter_set", kbmat[6], 64'h1);
        check_all("enter");

`ifdef PS2_TIMEOUT_EN
        // Stalled frame is aborted, then the receiver accepts a fresh frame.
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1), 1'b0);
        repeat (TIMEOUT + 10) @(negedge mck);
        exp_err++;
        check_all("timeout");
        send_frame(8'h29, 1'b0, 1'b0);
        check("space_set", kbmat[53], 64'h1);
        check_all("after_to");
`endif

        // Self-test completion clears every held key.
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'h29, 1'b0, 1'b0);
        send_frame(8'h59, 1'b0, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b0);
        check("selftest_clr", kbmat, 64'h0);
        check_all("selftest");

        // Short clock glitches are filtered out, idle and mid-frame.
        @(negedge mck);
        ps2_clk = 1'b0;
        @(negedge mck);
        ps2_clk = 1'b1;
        repeat (GAP) @(negedge mck);
        check_all("idle_glitch");
        send_frame(8'h1C, 1'b0, 1'b1);
        check("glitch_frame", kbmat, 64'h1 << 45);
        check_all("frame_glitch");

        // Randomised scan-code traffic.
        for (int n = 0; n < 90; n++) begin
            r = $urandom_range(0, 9);
            k = $urandom_range(0, 63);
            b = 8'($urandom);
            case (r)
                0, 1, 2, 3: send_key(k, 1'b0);
                4, 5:       send_key(k, 1'b1);
                6:          send_frame(b, 1'b0, 1'b0);
                7:          send_frame(b, 1'b1, 1'b0);
                8:          send_frame((b[0] ? 8'hAA : 8'hFC), 1'b0, 1'b0);
                default:    send_frame(km_key[k][8] ? 8'h1C : km_key[k][7:0], 1'b0, 1'b1);
            endcase
            check_all("rand");
        end

        // Asynchronous reset in the middle of a parity bit.
        send_frame(8'hAA, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("pre_rst", kbmat, (64'h1 << 6) | (64'h1 << 45));
        ps2_bit(1'b0, 1'b0);
        b = 8'h1C;
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
        @(negedge mck);
        ps2_dat = ~(^b);
        repeat (HALF) @(negedge mck);
        ps2_clk = 1'b0;
        repeat (HALF / 2) @(negedge mck);
        rin = 1'b1;
        #1;
        check("async_rst_kbmat", kbmat, 64'h0);
        check("async_rst_evt", 64'(key_evt), 64'h0);
        check("async_rst_err", 64'(frm_err), 64'h0);
        mdl_mat = 64'h0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        @(negedge mck);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (5) @(negedge mck);
        rin = 1'b0;
        repeat (GAP) @(negedge mck);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("post_rst", kbmat, 64'h1 << 45);
        check_all("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/z88_ps2kbd.md
Name: z88_ps2kbd

Overview:
- Keyboard front end for the Z88 gate array. Receives scan codes (set 2) from a PS/2 keyboard and maintains the 64-bit `kbmat` pressed-key matrix that the blink keyboard logic consumes.
- Receive-only. The block does not drive the PS/2 lines.
- Runs in the `mck` domain. Its `kbmat` output connects directly to the blink `kbmat` input.

Parameters:
- FILT, 8: consecutive identical `mck` samples required before a filtered PS/2 line level changes.
- TIMEOUT, 2000: `mck` cycles with no falling edge of the filtered `ps2_clk`, mid-frame, before the frame is aborted (about 203 us at 9.83 MHz).

Ports:
- mck  in  1  master clock, 9.83 MHz
- rin  in  1  asynchronous active-high reset
- ps2_clk  in  1  raw PS/2 clock, asynchronous, idles high
- ps2_dat  in  1  raw PS/2 data, asynchronous
- kbmat  out  64  key matrix: bit 8*col+row = 1 means pressed; column col is selected by `ca[8+col]` in blink
- key_evt  out  1  one-cycle pulse when a mapped make or break code updates `kbmat`
- frm_err  out  1  one-cycle pulse on parity error, bad start/stop bit, or timeout

Behaviour:
- Reset is asynchronous and active-high.
  - While `rin` is high: `kbmat` = 64'h0, `key_evt` = 0, `frm_err` = 0.
  - Receiver goes to IDLE; E0 and F0 prefix flags are cleared; filtered lines are forced to 1.
  - Reset asserted mid-frame discards the partial frame.
- Input conditioning:
  - Each PS/2 line passes through a 2-flop synchroniser, then a saturating counter filter of width FILT.
  - A falling edge is the filtered `ps2_clk` going 1->0. The data bit is sampled on the same `mck` cycle as that edge.
- Receiver FSM, advanced only on falling edges:
  - IDLE: if sampled data = 0 (start bit), go to DATA with bit count 0. A start bit of 1 stays in IDLE and pulses `frm_err`.
  - DATA: shift in 8 bits, LSB first. After bit 7, go to PARITY.
  - PARITY: store the bit. The 9-bit XOR of data and parity must be 1 (odd parity). Go to STOP.
  - STOP: stop bit must be 1. If stop and parity are both good, present the byte to the decoder with a one-cycle strobe. Otherwise pulse `frm_err` and drop the byte. Return to IDLE.
- Timeout: in any non-IDLE state, a counter clears on each falling edge. When it reaches TIMEOUT-1, the FSM returns to IDLE, `frm_err` pulses, and the prefix flags are kept.
- Decoder, acting on the byte strobe:
  - 8'hE0: set `ext`; no other action.
  - 8'hF0: set `brk`; no other action.
  - 8'hAA (self-test pass) or 8'hFC (self-test fail): clear all of `kbmat`; clear `ext` and `brk`; no `key_evt`.
  - Any other byte: look up `{ext, byte}` in the key map.
    - If mapped, set bit idx (`brk`=0) or clear it (`brk`=1) on the next cycle, and pulse `key_evt`.
    - If unmapped, leave `kbmat` unchanged and do not pulse `key_evt`.
    - In both cases clear `ext` and `brk`.
  - Typematic repeat of a make code rewrites a 1 over a 1 and still pulses `key_evt`. A break code for a key that is not pressed clears an already-0 bit and still pulses `key_evt`.
- Key map: a combinational function of `{ext, code}` returning a valid flag and a 6-bit idx. It covers all 64 Z88 keys per the team keymap sheet. Mandatory entries:
  - 5A -> 6 (ENTER)
  - 1C -> 45 (A)
  - 29 -> 53 (SPACE)
  - 12 -> 62 (left SHIFT)
  - 59 -> 15 (right SHIFT)
  - E0 75 -> 3 (UP)
  - E0 6B -> 4 (LEFT)
- Latency: `kbmat` updates 2 `mck` cycles after the falling edge of the stop bit (1 cycle decode, 1 cycle register), plus filter and synchroniser delay (FILT+2 cycles).
- Multiple keys may be held at once; each bit is independent. No ghost suppression is applied.

Optional Feature:
- PS2_TIMEOUT_EN
  - Defined: the timeout counter and abort are compiled in, as described above.
  - Undefined: no counter is built, and a stalled frame waits indefinitely for further edges. `frm_err` then pulses only for start, parity or stop errors.

Test Plan:
- Frame 1C (make A) with parity 0, then F0 1C -> `kbmat[45]` goes 1 with one `key_evt`, then returns to 0 with a second `key_evt`. No `frm_err` throughout.
- E0 75, then 12, then E0 F0 75 -> `kbmat` = bits 3 and 62 set, then only bit 62 set. `key_evt` pulses 3 times.
- Frame 5A sent with wrong parity bit -> `frm_err` pulses once; `kbmat` unchanged; the following correct 5A sets bit 6.
- Start bit plus 4 data bits, then clock held high for TIMEOUT+10 cycles (PS2_TIMEOUT_EN defined) -> one `frm_err`, FSM back in IDLE; the next full 29 frame sets bit 53.
- Hold 1C, 29 and 59 pressed, then send AA -> `kbmat` = 0 and no `key_evt`. A 1-cycle glitch on `ps2_clk` shorter than FILT causes no bit shift.
- Assert `rin` in the middle of the parity bit while bits 6 and 45 are set -> `kbmat` = 0 immediately (asynchronous). After release, a full 1C frame sets bit 45 only.
